// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative write-back write-allocate cache, one word per line
module cache_2way_wb #(
   parameter int ADDR_W     = 32,
   parameter int INDEX_BITS = 8,
   parameter int DATA_W     = 32
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Req,
   input  logic              WE,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic              Ready,
   output logic [DATA_W-1:0] RData,
   output logic              MemReq,
   output logic              MemWE,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemAck,
   input  logic [DATA_W-1:0] MemRData,
   output logic [31:0]       HitCnt,
   output logic [31:0]       MissCnt
);
   localparam int SETS  = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

   state_t                  state_q, state_d;
   logic [1:0][SETS-1:0]    v_q, d_q;
   logic [SETS-1:0]         lru_q;
   logic [TAG_W-1:0]        tag_q  [2][SETS];
   logic [DATA_W-1:0]       data_q [2][SETS];
   logic                    vic_q, vic_d, missed_q, missed_d;
   logic [TAG_W-1:0]        mtag_q, mtag_d;
   logic [INDEX_BITS-1:0]   midx_q, midx_d;
   logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]             hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_W-1:0]        tag;
   logic                    hit0, hit1, hit_w, miss, victim, vic_dirty, fill, wr;
   logic                    unused_addr;

   assign idx         = Addr[INDEX_BITS+1:2];
   assign tag         = Addr[ADDR_W-1:INDEX_BITS+2];
   assign unused_addr = ^Addr[1:0];
   assign hit0        = v_q[0][idx] && (tag_q[0][idx] == tag);
   assign hit1        = v_q[1][idx] && (tag_q[1][idx] == tag);
   assign hit_w       = !hit0;
   assign Ready       = (state_q == IDLE) && Req && (hit0 || hit1);
   assign miss        = (state_q == IDLE) && Req && !(hit0 || hit1);
   assign RData       = data_q[hit_w][idx];
   assign victim      = !v_q[0][idx] ? 1'b0 : !v_q[1][idx] ? 1'b1 : lru_q[idx];
   assign vic_dirty   = v_q[victim][idx] && d_q[victim][idx];
   assign fill        = (state_q == REFILL) && MemAck;
   assign wr          = Ready && WE;
   assign MemReq      = mem_req_q;
   assign MemWE       = mem_we_q;
   assign MemAddr     = mem_addr_q;
   assign MemWData    = mem_wdata_q;
   assign HitCnt      = hit_cnt_q;
   assign MissCnt     = miss_cnt_q;

   // Next-state, memory-request registers and saturating performance counters
   always_comb begin
      state_d     = state_q;
      vic_d       = vic_q;
      mtag_d      = mtag_q;
      midx_d      = midx_q;
      missed_d    = missed_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_cnt_d   = (Ready && !missed_q && hit_cnt_q != '1) ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d  = (miss && miss_cnt_q != '1) ? miss_cnt_q + 32'd1 : miss_cnt_q;
      unique case (state_q)
         IDLE: begin
            missed_d = miss;
            if (miss) begin
               vic_d       = victim;
               mtag_d      = tag;
               midx_d      = idx;
               state_d     = vic_dirty ? WB : REFILL;
               mem_req_d   = 1'b1;
               mem_we_d    = vic_dirty;
               mem_addr_d  = vic_dirty ? {tag_q[victim][idx], idx, 2'b00} : {tag, idx, 2'b00};
               mem_wdata_d = data_q[victim][idx];
            end
         end
         WB: begin
            if (MemAck) begin
               state_d    = REFILL;
               mem_we_d   = 1'b0;
               mem_addr_d = {mtag_q, midx_q, 2'b00};
            end
         end
         REFILL: begin
            if (MemAck) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state with asynchronous clear; miss bookkeeping is held across the miss
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         vic_q       <= 1'b0;
         mtag_q      <= '0;
         midx_q      <= '0;
         missed_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         vic_q       <= vic_d;
         mtag_q      <= mtag_d;
         midx_q      <= midx_d;
         missed_q    <= missed_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Valid, dirty and LRU bits: cleared by reset, set by refill and hits
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         v_q   <= '0;
         d_q   <= '0;
         lru_q <= '0;
      end else begin
         if (fill) begin
            v_q[vic_q][midx_q] <= 1'b1;
            d_q[vic_q][midx_q] <= 1'b0;
         end
         if (wr)
            d_q[hit_w][idx] <= 1'b1;
         if (Ready)
            lru_q[idx] <= ~hit_w;
      end
   end

   // Tag and data arrays are not reset; valid bits qualify their contents
   always_ff @(posedge CLK) begin
      if (fill) begin
         tag_q[vic_q][midx_q]  <= mtag_q;
         data_q[vic_q][midx_q] <= MemRData;
      end else if (wr) begin
         data_q[hit_w][idx] <= WData;
      end
   end
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: directed self-checking bench for cache_2way_wb
module tb_cache_2way_wb;
   logic        CLK, Reset_n, Req, WE, MemAck;
   logic [31:0] Addr, WData, RData, MemAddr, MemWData, MemRData, HitCnt, MissCnt;
   logic        Ready, MemReq, MemWE;
   int          n_cmp = 0;
   int          n_bad = 0;

   cache_2way_wb dut (
      .CLK(CLK), .Reset_n(Reset_n), .Req(Req), .WE(WE), .Addr(Addr), .WData(WData),
      .Ready(Ready), .RData(RData), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
      .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData), .HitCnt(HitCnt), .MissCnt(MissCnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic test_reset;
      Reset_n = 1'b0; Req = 1'b0; WE = 1'b0; Addr = '0; WData = '0; MemAck = 1'b0; MemRData = '0;
      repeat (2) @(negedge CLK);
      #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", Ready); end
      n_cmp++; if (MemReq !== 1'b0 || MemWE !== 1'b0) begin n_bad++; $display("FAIL rst_memreq: got %b/%b want 0/0", MemReq, MemWE); end
      n_cmp++; if (MemAddr !== 32'h0 || MemWData !== 32'h0) begin n_bad++; $display("FAIL rst_memaddr: got %h/%h want 0/0", MemAddr, MemWData); end
      n_cmp++; if (HitCnt !== 32'h0 || MissCnt !== 32'h0) begin n_bad++; $display("FAIL rst_cnt: got %h/%h want 0/0", HitCnt, MissCnt); end
      Reset_n = 1'b1;
   endtask

   task automatic test_clean_miss;
      @(negedge CLK); Req = 1'b1; WE = 1'b0; Addr = 32'h40; #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL miss_ready: got %b want 0", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (MissCnt !== 32'd1) begin n_bad++; $display("FAIL miss_cnt: got %0d want 1", MissCnt); end
      n_cmp++; if (MemReq !== 1'b1 || MemWE !== 1'b0) begin n_bad++; $display("FAIL miss_req: got %b/%b want 1/0", MemReq, MemWE); end
      n_cmp++; if (MemAddr !== 32'h40) begin n_bad++; $display("FAIL miss_addr: got %h want 00000040", MemAddr); end
      MemAck = 1'b1; MemRData = 32'hDEAD_BEEF;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL miss_done: got %b/%h want 1/deadbeef", Ready, RData); end
      n_cmp++; if (MemReq !== 1'b0) begin n_bad++; $display("FAIL miss_reqdrop: got %b want 0", MemReq); end
      @(negedge CLK); Req = 1'b0; #1;
      n_cmp++; if (HitCnt !== 32'd0) begin n_bad++; $display("FAIL miss_hitcnt: got %0d want 0", HitCnt); end
   endtask

   task automatic test_hit;
      @(negedge CLK); Req = 1'b1; WE = 1'b0; Addr = 32'h40; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL hit_read: got %b/%h want 1/deadbeef", Ready, RData); end
      n_cmp++; if (MemReq !== 1'b0) begin n_bad++; $display("FAIL hit_memreq: got %b want 0", MemReq); end
      @(negedge CLK); Req = 1'b0; #1;
      n_cmp++; if (HitCnt !== 32'd1) begin n_bad++; $display("FAIL hit_cnt: got %0d want 1", HitCnt); end
      @(negedge CLK); MemAck = 1'b1;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (MemReq !== 1'b0 || MissCnt !== 32'd1) begin n_bad++; $display("FAIL stray_ack: got %b/%0d want 0/1", MemReq, MissCnt); end
   endtask

   task automatic test_dirty_evict;
      @(negedge CLK); Req = 1'b1; WE = 1'b1; Addr = 32'h40; WData = 32'h1234_5678; #1;
      n_cmp++; if (Ready !== 1'b1) begin n_bad++; $display("FAIL wr_hit: got %b want 1", Ready); end
      @(negedge CLK); WE = 1'b0; Addr = 32'h440; #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL ev1_ready: got %b want 0", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (MemAddr !== 32'h440 || MemWE !== 1'b0) begin n_bad++; $display("FAIL ev1_refill: got %h/%b want 00000440/0", MemAddr, MemWE); end
      MemAck = 1'b1; MemRData = 32'h4404_4044;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'h4404_4044) begin n_bad++; $display("FAIL ev1_done: got %b/%h want 1/44044044", Ready, RData); end
      @(negedge CLK); Addr = 32'h840; #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL ev2_ready: got %b want 0", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (MemReq !== 1'b1 || MemWE !== 1'b1) begin n_bad++; $display("FAIL wb_req: got %b/%b want 1/1", MemReq, MemWE); end
      n_cmp++; if (MemAddr !== 32'h40 || MemWData !== 32'h1234_5678) begin n_bad++; $display("FAIL wb_data: got %h/%h want 00000040/12345678", MemAddr, MemWData); end
      n_cmp++; if (MissCnt !== 32'd3) begin n_bad++; $display("FAIL ev_misscnt: got %0d want 3", MissCnt); end
      MemAck = 1'b1;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (MemReq !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 32'h840) begin n_bad++; $display("FAIL ev2_refill: got %b/%b/%h want 1/0/00000840", MemReq, MemWE, MemAddr); end
      MemAck = 1'b1; MemRData = 32'h8408_4084;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'h8408_4084) begin n_bad++; $display("FAIL ev2_done: got %b/%h want 1/84084084", Ready, RData); end
      @(negedge CLK); Addr = 32'h440; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'h4404_4044) begin n_bad++; $display("FAIL ev_keep: got %b/%h want 1/44044044", Ready, RData); end
      @(negedge CLK); Req = 1'b0; #1;
      n_cmp++; if (HitCnt !== 32'd3) begin n_bad++; $display("FAIL ev_hitcnt: got %0d want 3", HitCnt); end
   endtask

   task automatic test_write_miss;
      @(negedge CLK); Req = 1'b1; WE = 1'b1; Addr = 32'h80; WData = 32'hA5A5_A5A5; #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL wm_ready: got %b want 0", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (MemReq !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 32'h80) begin n_bad++; $display("FAIL wm_refill: got %b/%b/%h want 1/0/00000080", MemReq, MemWE, MemAddr); end
      MemAck = 1'b1; MemRData = 32'h1111_1111;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1) begin n_bad++; $display("FAIL wm_done: got %b want 1", Ready); end
      @(negedge CLK); WE = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL wm_read: got %b/%h want 1/a5a5a5a5", Ready, RData); end
      @(negedge CLK); WE = 1'b1; Addr = 32'h480; WData = 32'h0;
      @(negedge CLK); MemAck = 1'b1; MemRData = 32'h0;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1) begin n_bad++; $display("FAIL wm2_done: got %b want 1", Ready); end
      @(negedge CLK); WE = 1'b0; Addr = 32'h880;
      @(negedge CLK); #1;
      n_cmp++; if (MemWE !== 1'b1 || MemAddr !== 32'h80 || MemWData !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL wm_dirty_wb: got %b/%h/%h want 1/00000080/a5a5a5a5", MemWE, MemAddr, MemWData); end
      MemAck = 1'b1;
      @(negedge CLK);
      @(negedge CLK); MemAck = 1'b0; Req = 1'b0;
   endtask

   task automatic test_req_drop;
      @(negedge CLK); Req = 1'b1; WE = 1'b0; Addr = 32'hC0;
      @(negedge CLK); Req = 1'b0; Addr = 32'h0; #1;
      n_cmp++; if (MemReq !== 1'b1 || MemAddr !== 32'hC0) begin n_bad++; $display("FAIL drop_hold: got %b/%h want 1/000000c0", MemReq, MemAddr); end
      MemAck = 1'b1; MemRData = 32'hC0C0_C0C0;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (MemReq !== 1'b0) begin n_bad++; $display("FAIL drop_end: got %b want 0", MemReq); end
      @(negedge CLK); Req = 1'b1; Addr = 32'hC0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'hC0C0_C0C0) begin n_bad++; $display("FAIL drop_installed: got %b/%h want 1/c0c0c0c0", Ready, RData); end
      n_cmp++; if (MissCnt !== 32'd7) begin n_bad++; $display("FAIL drop_misscnt: got %0d want 7", MissCnt); end
      @(negedge CLK); Req = 1'b0; #1;
      n_cmp++; if (HitCnt !== 32'd5) begin n_bad++; $display("FAIL drop_hitcnt: got %0d want 5", HitCnt); end
   endtask

   task automatic test_reset_mid;
      @(negedge CLK); Req = 1'b1; WE = 1'b0; Addr = 32'h100;
      @(negedge CLK); #1;
      n_cmp++; if (MemReq !== 1'b1) begin n_bad++; $display("FAIL rm_pre: got %b want 1", MemReq); end
      Reset_n = 1'b0; #1;
      n_cmp++; if (MemReq !== 1'b0 || MemAddr !== 32'h0 || Ready !== 1'b0) begin n_bad++; $display("FAIL rm_async: got %b/%h/%b want 0/00000000/0", MemReq, MemAddr, Ready); end
      n_cmp++; if (HitCnt !== 32'd0 || MissCnt !== 32'd0) begin n_bad++; $display("FAIL rm_cnt: got %0d/%0d want 0/0", HitCnt, MissCnt); end
      @(negedge CLK); Reset_n = 1'b1; Addr = 32'h40; #1;
      n_cmp++; if (Ready !== 1'b0) begin n_bad++; $display("FAIL rm_invalid: got %b want 0", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (MissCnt !== 32'd1 || MemReq !== 1'b1 || MemAddr !== 32'h40) begin n_bad++; $display("FAIL rm_miss: got %0d/%b/%h want 1/1/00000040", MissCnt, MemReq, MemAddr); end
      MemAck = 1'b1; MemRData = 32'h5555_AAAA;
      @(negedge CLK); MemAck = 1'b0; #1;
      n_cmp++; if (Ready !== 1'b1 || RData !== 32'h5555_AAAA) begin n_bad++; $display("FAIL rm_done: got %b/%h want 1/5555aaaa", Ready, RData); end
      @(negedge CLK); Req = 1'b0;
   endtask

   task automatic test_hit_sat;
      @(negedge CLK); force dut.hit_cnt_d = 32'hFFFF_FFFE;
      @(negedge CLK); release dut.hit_cnt_d; #1;
      n_cmp++; if (HitCnt !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL sat_preload: got %h want fffffffe", HitCnt); end
      @(negedge CLK); Req = 1'b1; WE = 1'b0; Addr = 32'h40; #1;
      n_cmp++; if (Ready !== 1'b1) begin n_bad++; $display("FAIL sat_ready: got %b want 1", Ready); end
      @(negedge CLK); #1;
      n_cmp++; if (HitCnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_top: got %h want ffffffff", HitCnt); end
      @(negedge CLK); Req = 1'b0; #1;
      n_cmp++; if (HitCnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffffffff", HitCnt); end
   endtask

   initial begin
      test_reset;
      test_clean_miss;
      test_hit;
      test_dirty_evict;
      test_write_miss;
      test_req_drop;
      test_reset_mid;
      test_hit_sat;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cache_2way_wb.md
CACHE_2WAY_WB -- requirements
Module: cache_2way_wb

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width; word-aligned, Addr[1:0] ignored.
REQ-002 Parameter INDEX_BITS, default 8: sets = 2^INDEX_BITS; TAG_W = ADDR_W-INDEX_BITS-2.
REQ-003 Parameter DATA_W, default 32: line = one word of DATA_W bits.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK  in  1  clock, all state on rising edge.
REQ-006 Reset_n  in  1  asynchronous active-low reset.
REQ-007 Req  in  1  CPU access request; Addr/WE/WData held stable until Ready.
REQ-008 WE  in  1  1 = write, 0 = read.
REQ-009 Addr  in  ADDR_W  byte address; index = Addr[INDEX_BITS+1:2], tag = Addr[ADDR_W-1:INDEX_BITS+2].
REQ-010 WData  in  DATA_W  write data.
REQ-011 Ready  out  1  access complete this cycle.
REQ-012 RData  out  DATA_W  read data, valid when Ready && !WE.
REQ-013 MemReq  out  1  memory request, held until MemAck.
REQ-014 MemWE  out  1  1 = writeback, 0 = refill read.
REQ-015 MemAddr  out  ADDR_W  word address, [1:0]=0.
REQ-016 MemWData  out  DATA_W  writeback data.
REQ-017 MemAck  in  1  memory completes current request this cycle; ignored when MemReq=0.
REQ-018 MemRData  in  DATA_W  refill data, valid with MemAck.
REQ-019 HitCnt, MissCnt  out  32 each  performance counters.

Function
REQ-020 Organisation SHALL be 2-way set-associative, write-back, write-allocate; per set: 2x{V, D, tag, data}, one LRU bit (points to least-recently-used way).
REQ-021 FSM states SHALL be IDLE, WB, REFILL; Ready SHALL be asserted only in IDLE.
REQ-022 IDLE, Req && hit in way w: Ready=1 combinationally same cycle; read -> RData = data[w]; write -> at clock edge data[w]<=WData, D[w]<=1; LRU[set]<=~w.
REQ-023 IDLE, Req && miss: Ready=0; victim = first invalid way (way 0 before way 1), else way LRU[set]; victim registered; next state WB if victim V&&D else REFILL.
REQ-024 WB: MemReq=1, MemWE=1, MemAddr={victim tag, index, 2'b00}, MemWData=victim data; on MemAck -> REFILL.
REQ-025 REFILL: MemReq=1, MemWE=0, MemAddr={tag, index, 2'b00}; on MemAck victim way <= {V=1, D=0, tag, MemRData}, -> IDLE.
REQ-026 After REFILL the re-lookup in IDLE SHALL hit; a write completes as a hit write (REQ-022).
REQ-027 Latency: hit 0 extra cycles; clean miss = refill ack cycles + 1; dirty miss = writeback + refill ack cycles + 1.
REQ-028 Mem outputs SHALL be registered-stable for the whole request; MemReq=0, MemWE=0 in IDLE.
REQ-029 Req deasserted during WB/REFILL SHALL NOT abort; the transaction completes and the line is installed.
REQ-030 MissCnt increments once per miss entry from IDLE; HitCnt increments on Ready only for accesses with no preceding miss; both saturate at 32'hFFFF_FFFF.
REQ-031 Same-cycle MemAck on entry to a state is impossible (MemReq registered); MemAck outside WB/REFILL SHALL be ignored.

Reset
REQ-032 Reset_n=0 SHALL asynchronously clear all V, D, LRU bits, FSM -> IDLE, MemReq=0, MemWE=0, MemAddr=0, MemWData=0, HitCnt=0, MissCnt=0; Ready=0 while reset asserted.
REQ-033 Tag/data arrays SHALL NOT be reset; reset mid-miss abandons the transaction, MemReq falls immediately.

Verification
REQ-034 Post-reset read Addr=0x0000_0040 -> MissCnt=1, MemReq/MemWE=0/MemAddr=0x40; MemAck with MemRData=0xDEADBEEF -> next cycle Ready=1, RData=0xDEADBEEF, HitCnt=0.
REQ-035 Repeat read 0x40 -> Ready same cycle, RData=0xDEADBEEF, HitCnt=1, no MemReq.
REQ-036 Write 0x40 data 0x1234_5678 (hit); read 0x440 and 0x840 (same set, default params) -> second miss evicts LRU way holding 0x40: WB MemAddr=0x40, MemWData=0x1234_5678, then REFILL MemAddr=0x840.
REQ-037 Write miss to 0x80 with WData=0xA5A5_A5A5: REFILL MemAddr=0x80, then Ready, line D=1; later read hits 0xA5A5_A5A5.
REQ-038 Reset_n pulsed low during REFILL -> MemReq=0 immediately, counters 0, next read of same address misses.
REQ-039 Force HitCnt near 32'hFFFF_FFFF (long hit loop or preload) -> counter holds at 32'hFFFF_FFFF.
